// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo types, constants and cfg/position conversion helpers
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    localparam int         CFG_FWD_BIT       = 7;
    localparam logic [6:0] DEFAULT_MAX_ANGLE = 7'd90;

    // Reverse with angle 0 collapses to 0, so there is only one encoding of centre.
    function automatic logic signed [7:0] cfg_to_pos(input logic [7:0] c,
                                                     input logic [6:0] max_angle);
        logic [6:0] ang;
        ang = (c[6:0] > max_angle) ? max_angle : c[6:0];
        return c[CFG_FWD_BIT] ? $signed({1'b0, ang}) : -$signed({1'b0, ang});
    endfunction

    function automatic logic [7:0] pos_to_cfg(input logic signed [7:0] p);
        return p[7] ? {1'b0, ~p[6:0] + 7'd1} : {1'b1, p[6:0]};
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// rtl/servo_tick_gen.sv - free-running one-cycle update tick, one per PWM frame
module servo_tick_gen #(
    parameter logic [23:0] CLK_FRE = 24'd12_000_000,
    parameter logic [7:0]  STEP_MS = 8'd20
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [31:0] TICK_CYCLES = ({8'd0, CLK_FRE} / 32'd1000) * {24'd0, STEP_MS};
    localparam logic [31:0] TICK_LAST   = (TICK_CYCLES == 32'd0) ? 32'd0 : TICK_CYCLES - 32'd1;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == TICK_LAST) ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TICK_LAST);

endmodule

// File: rtl/servo_ramp_ctl.sv
// rtl/servo_ramp_ctl.sv - ramps servo position toward commanded target one degree per tick
module servo_ramp_ctl
    import servo_pkg::*;
#(
    parameter logic [23:0] CLK_FRE     = 24'd12_000_000,
    parameter logic [7:0]  STEP_MS     = 8'd20,
    parameter logic [6:0]  MAX_ANGLE   = DEFAULT_MAX_ANGLE,
    parameter logic [7:0]  DWELL_TICKS = 8'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_cfg,
    input  logic       sweep_en,
    output logic [7:0] cfg,
    output logic       busy,
    output logic       at_target
);

    localparam logic signed [7:0] MAX_POS = $signed({1'b0, MAX_ANGLE});

    state_e            state_q, state_d;
    logic signed [7:0] pos_q, pos_d;
    logic signed [7:0] tgt_q, tgt_d;
    logic [7:0]        dwell_q, dwell_d;
    logic [7:0]        cfg_q, cfg_d;
    logic signed [7:0] cmd_pos;
    logic signed [7:0] sweep_pos;
    logic              tick;
    logic              accept;

    servo_tick_gen #(
        .CLK_FRE (CLK_FRE),
        .STEP_MS (STEP_MS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd_ready = ~rst & (state_q != ST_RAMP);
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state_q == ST_RAMP);
    assign at_target = (pos_q == tgt_q);
    assign cfg       = cfg_q;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        tgt_d     = tgt_q;
        dwell_d   = dwell_q;
        cmd_pos   = cfg_to_pos(cmd_cfg, MAX_ANGLE);
        sweep_pos = (pos_q > 8'sd0) ? -MAX_POS : MAX_POS;

        case (state_q)
            ST_IDLE, ST_DWELL: begin
                // A command always wins over sweep and preempts any dwell in progress.
                if (accept) begin
                    tgt_d   = cmd_pos;
                    dwell_d = 8'd0;
                    state_d = (cmd_pos == pos_q) ? ST_DWELL : ST_RAMP;
                end else if (state_q == ST_IDLE) begin
                    if (sweep_en) begin
                        tgt_d   = sweep_pos;
                        dwell_d = 8'd0;
                        state_d = (sweep_pos == pos_q) ? ST_DWELL : ST_RAMP;
                    end
                end else if (tick) begin
                    if (dwell_q == DWELL_TICKS - 8'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            end
            ST_RAMP: begin
                if (tick) begin
                    pos_d = (tgt_q > pos_q) ? pos_q + 8'sd1 : pos_q - 8'sd1;
                    if (pos_d == tgt_q) begin
                        dwell_d = 8'd0;
                        state_d = ST_DWELL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered from the next position so cfg and at_target move on the same edge.
        cfg_d = pos_to_cfg(pos_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= 8'sd0;
            tgt_q   <= 8'sd0;
            dwell_q <= 8'd0;
            cfg_q   <= 8'h80;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            cfg_q   <= cfg_d;
        end
    end

endmodule

// File: tb/tb_servo_ramp_ctl.sv
// tb/tb_servo_ramp_ctl.sv - directed self-checking bench for servo_ramp_ctl
module tb_servo_ramp_ctl;
    import servo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_cfg = 8'h00;
    logic       sweep_en = 1'b0;
    logic       cmd_ready;
    logic [7:0] cfg;
    logic       busy;
    logic       at_target;

    int checks = 0;
    int errors = 0;

    logic [7:0] flip_exp [5] = '{8'h82, 8'h81, 8'h80, 8'h01, 8'h02};

    servo_ramp_ctl #(
        .CLK_FRE     (24'd1000),
        .STEP_MS     (8'd4),
        .MAX_ANGLE   (7'd90),
        .DWELL_TICKS (8'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_cfg   (cmd_cfg),
        .sweep_en  (sweep_en),
        .cfg       (cfg),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_change(input logic [7:0] prev, input int limit, output int cycles);
        int i;
        i = 0;
        cycles = -1;
        while (cycles < 0 && i < limit) begin
            @(negedge clk);
            i++;
            if (cfg !== prev) cycles = i;
        end
    endtask

    task automatic wait_cfg(input logic [7:0] want, input int limit, output int cycles);
        int i;
        i = 0;
        cycles = -1;
        while (cycles < 0 && i < limit) begin
            @(negedge clk);
            i++;
            if (cfg === want) cycles = i;
        end
    endtask

    task automatic send_cmd(input logic [7:0] c, output bit ok);
        int i;
        i = 0;
        ok = 1'b0;
        cmd_cfg = c;
        cmd_valid = 1'b1;
        while (!ok && i < 500) begin
            if (cmd_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            i++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg !== 8'h80) begin
            errors++;
            $display("FAIL reset_cfg: got %h want 80", cfg);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (at_target !== 1'b1) begin
            errors++;
            $display("FAIL reset_at_target: got %b want 1", at_target);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_forward_ramp();
        bit         ok;
        int         cyc;
        logic [7:0] prev;
        logic [7:0] exp_cfg;
        send_cmd(8'h85, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fwd_accept: got no handshake want handshake");
        end
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || at_target !== 1'b0) begin
            errors++;
            $display("FAIL fwd_ramp_flags: got busy=%b ready=%b at=%b want 1 0 0", busy, cmd_ready, at_target);
        end
        prev = 8'h80;
        for (int k = 1; k <= 5; k++) begin
            exp_cfg = 8'h80 + 8'(k);
            wait_change(prev, 12, cyc);
            checks++;
            if (cfg !== exp_cfg) begin
                errors++;
                $display("FAIL fwd_step%0d: got %h want %h", k, cfg, exp_cfg);
            end
            if (k > 1) begin
                checks++;
                if (cyc !== 4) begin
                    errors++;
                    $display("FAIL fwd_interval%0d: got %0d want 4", k, cyc);
                end
            end
            prev = cfg;
        end
        checks++;
        if (busy !== 1'b0 || at_target !== 1'b1 || dut.state_q !== ST_DWELL) begin
            errors++;
            $display("FAIL fwd_arrive: got busy=%b at=%b state=%0d want 0 1 2", busy, at_target, dut.state_q);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (dut.state_q !== ST_DWELL) begin
            errors++;
            $display("FAIL fwd_dwell_hold: got state %0d want 2", dut.state_q);
        end
        @(negedge clk);
        checks++;
        if (dut.state_q !== ST_IDLE || cfg !== 8'h85) begin
            errors++;
            $display("FAIL fwd_dwell_end: got state %0d cfg %h want 0 85", dut.state_q, cfg);
        end
    endtask

    task automatic test_direction_flip();
        bit         ok;
        int         cyc;
        logic [7:0] prev;
        send_cmd(8'h83, ok);
        prev = 8'h85;
        wait_change(prev, 12, cyc);
        prev = cfg;
        wait_change(prev, 12, cyc);
        checks++;
        if (cfg !== 8'h83) begin
            errors++;
            $display("FAIL flip_start: got %h want 83", cfg);
        end
        send_cmd(8'h02, ok);
        checks++;
        if (!ok || dut.tgt_q !== 8'hFE) begin
            errors++;
            $display("FAIL flip_accept: got ok=%b tgt %h want 1 fe", ok, dut.tgt_q);
        end
        prev = 8'h83;
        for (int k = 0; k < 5; k++) begin
            wait_change(prev, 12, cyc);
            checks++;
            if (cfg !== flip_exp[k]) begin
                errors++;
                $display("FAIL flip_step%0d: got %h want %h", k, cfg, flip_exp[k]);
            end
            prev = cfg;
        end
        checks++;
        if (busy !== 1'b0 || at_target !== 1'b1) begin
            errors++;
            $display("FAIL flip_arrive: got busy=%b at=%b want 0 1", busy, at_target);
        end
    endtask

    task automatic test_sweep_preempt();
        bit ok;
        int cyc;
        int i;
        sweep_en = 1'b1;
        i = 0;
        while (busy !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (busy !== 1'b1 || dut.tgt_q !== 8'h5A) begin
            errors++;
            $display("FAIL sweep_start: got busy=%b tgt %h want 1 5a", busy, dut.tgt_q);
        end
        wait_cfg(8'hDA, 500, cyc);
        checks++;
        if (cyc < 0 || dut.state_q !== ST_DWELL) begin
            errors++;
            $display("FAIL sweep_reach: got cfg %h state %0d want da 2", cfg, dut.state_q);
        end
        send_cmd(8'h00, ok);
        checks++;
        if (!ok || dut.tgt_q !== 8'h00 || dut.state_q !== ST_RAMP) begin
            errors++;
            $display("FAIL sweep_preempt: got ok=%b tgt %h state %0d want 1 00 1", ok, dut.tgt_q, dut.state_q);
        end
        sweep_en = 1'b0;
        wait_cfg(8'h80, 500, cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL sweep_return: got cfg %h want 80", cfg);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (dut.state_q !== ST_IDLE || cfg !== 8'h80 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_off_idle: got state %0d cfg %h busy %b want 0 80 0", dut.state_q, cfg, busy);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        int cyc;
        send_cmd(8'hFF, ok);
        checks++;
        if (!ok || dut.tgt_q !== 8'h5A || busy !== 1'b1) begin
            errors++;
            $display("FAIL clamp_tgt: got ok=%b tgt %h busy %b want 1 5a 1", ok, dut.tgt_q, busy);
        end
        wait_cfg(8'hDA, 500, cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL clamp_reach: got cfg %h want da", cfg);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (cfg !== 8'hDA || at_target !== 1'b1 || dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL clamp_hold: got cfg %h at %b state %0d want da 1 0", cfg, at_target, dut.state_q);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int i;
        int bad;
        send_cmd(8'h85, ok);
        cmd_cfg = 8'h03;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0 || dut.state_q !== ST_RAMP) begin
            errors++;
            $display("FAIL hs_ready_low: got ready %b state %0d want 0 1", cmd_ready, dut.state_q);
        end
        i = 0;
        bad = 0;
        while (cmd_ready !== 1'b1 && i < 500) begin
            if (dut.tgt_q !== 8'h05) bad++;
            @(negedge clk);
            i++;
        end
        checks++;
        if (i >= 500 || bad != 0) begin
            errors++;
            $display("FAIL hs_hold_tgt: got cycles %0d tgt changes %0d want <500 0", i, bad);
        end
        checks++;
        if (dut.state_q !== ST_DWELL || cfg !== 8'h85) begin
            errors++;
            $display("FAIL hs_first_dwell: got state %0d cfg %h want 2 85", dut.state_q, cfg);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (dut.tgt_q !== 8'hFD || dut.state_q !== ST_RAMP || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_accept: got tgt %h state %0d ready %b want fd 1 0", dut.tgt_q, dut.state_q, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_forward_ramp();
        test_direction_flip();
        test_sweep_preempt();
        test_clamp();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
